display_share_arbiter: RTL
==========================

Name: display_share_arbiter

Overview:
- Shares the 8-digit hex 7-segment display among N_REQ requesters using round-robin arbitration with a guaranteed minimum hold time.
- Drives the display driver's inputs: 32-bit value, power_on and the digit-refresh clock clk_display.
- Sits between application blocks (ALU result, counters, debug registers) and the display driver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- REFRESH_DIV, 50000, clk cycles per clk_display half-period (>=1).
- HOLD_CYCLES, 25000000, minimum clk cycles an owner keeps the display before it can be preempted (>=2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  request per client; level, held while the client wants the display.
- data_in  input  32*N_REQ  client values; client i on bits [32*i+31:32*i].
- grant  output  N_REQ  one-hot ownership; all zero when no owner.
- owner_id  output  max(1,$clog2(N_REQ))  index of the current owner; valid when busy=1.
- busy  output  1  1 while any client owns the display.
- numero_entrada  output  32  value sent to the display driver.
- power_on  output  1  display enable to the driver.
- clk_display  output  1  square-wave digit-refresh clock to the driver.

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: grant=0, owner_id=0, busy=0, numero_entrada=0, power_on=0, clk_display=0, hold counter=0, refresh counter=0, RR pointer=0 (client 0 has highest priority first).
- Refresh divider:
  - Free-running in every state. clk_display toggles when the refresh counter reaches REFRESH_DIV-1, and the counter then wraps to 0.
  - Period is 2*REFRESH_DIV clk cycles. The divider is independent of arbitration.
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - grant=0, busy=0, power_on=0, numero_entrada holds its last value.
  - If any req bit is set, the winner is the first set bit searching from the RR pointer upward with wrap.
  - Next cycle: state=OWN, grant/owner_id/busy set, hold counter=0.
- OWN:
  - power_on=1.
  - numero_entrada is registered from data_in of the owner every cycle, so it follows the owner's data with 1-cycle latency.
  - Hold counter increments and saturates at HOLD_CYCLES.
- Leaving OWN, release: the owner's req goes to 0, at any time. Next cycle: state=GAP.
- Leaving OWN, preemption: hold counter == HOLD_CYCLES and some other req bit is set. Next cycle: state=GAP.
- Staying in OWN: hold expired but no other request means the owner keeps the display indefinitely.
- Release and preemption in the same cycle is treated as release; the result is identical, state=GAP.
- On leaving OWN, the RR pointer becomes owner_id+1 modulo N_REQ.
- GAP (exactly 1 cycle):
  - grant=0, busy=0, power_on=0; this blanks the display to avoid a mixed-value frame.
  - numero_entrada holds its value.
  - Next state: arbitration as in IDLE using the updated pointer; if no req is set, go to IDLE.
- Grant latency:
  - From IDLE: req rising to grant is 1 cycle.
  - Handover: 2 cycles from the release or preemption decision to the new grant.
- The grant is never given to a client whose req is 0. A client that drops and re-raises req during GAP competes normally.
- req bits for indices >= N_REQ do not exist; out-of-range RR pointer values are impossible by construction (modulo wrap).
- reset_n asserted mid-operation: all outputs go to reset values immediately (asynchronous), and the FSM returns to IDLE. The first arbitration after reset release starts from client 0.

Test Plan:
- N_REQ=4, HOLD_CYCLES=8, REFRESH_DIV=2 for all scenarios.
- Refresh: idle, no req -> clk_display toggles every 2 cycles (period 4); power_on=0, grant=0.
- Single request:
  - req=0010, data_in[63:32]=32'hDEADBEEF -> grant=0010 one cycle later, owner_id=1, busy=1, power_on=1, numero_entrada=32'hDEADBEEF the cycle after.
  - Client 1 then changes data to 32'h12345678 -> numero_entrada follows 1 cycle later.
- Early release: client 1 drops req after 3 cycles of ownership -> one GAP cycle (power_on=0, grant=0), then IDLE; numero_entrada stays 32'h12345678.
- Preemption and round-robin:
  - req=1111 held -> grant order is 0001, 0010, 0100, 1000, 0001.
  - Each owner holds exactly 8 cycles plus a 1-cycle GAP with power_on=0 between owners.
- No contender: only client 2 requests for 40 cycles -> grant=0100 is held throughout with no GAP, despite hold expiry.
- Async reset: reset_n pulled low mid-OWN, between clk edges -> grant=0, power_on=0, numero_entrada=0, clk_display=0 immediately.
  - After release with req=1000 -> grant=1000 one cycle later; the pointer starts at 0.

Source files
------------

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared 8-digit 7-segment display, with a minimum hold time per owner
// and a one-cycle blanking gap on every handover. Also generates the digit-refresh clock.
module display_share_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [N_REQ-1:0]                            req,
  input  logic [32*N_REQ-1:0]                         data_in,
  output logic [N_REQ-1:0]                            grant,
  output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0]  owner_id,
  output logic                                        busy,
  output logic [31:0]                                 numero_entrada,
  output logic                                        power_on,
  output logic                                        clk_display
);

  localparam int unsigned IdW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   owner_q, owner_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d, hold_inc;
  logic [31:0]      num_q, num_d;
  logic [RefW-1:0]  refresh_q;
  logic             clk_disp_q;

  logic [IdW-1:0]   win;
  logic             win_valid;
  logic [IdW:0]     cand;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] others;
  logic             owner_req;
  logic [31:0]      owner_data;

  // Refresh divider runs regardless of arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_q  <= '0;
      clk_disp_q <= 1'b0;
    end else if (refresh_q == RefW'(REFRESH_DIV - 1)) begin
      refresh_q  <= '0;
      clk_disp_q <= ~clk_disp_q;
    end else begin
      refresh_q  <= refresh_q + 1'b1;
    end
  end

  // Walk offsets from high to low so the smallest offset from the pointer wins.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IdW + 1)'(k);
      if (cand >= (IdW + 1)'(N_REQ)) begin
        cand = cand - (IdW + 1)'(N_REQ);
      end
      if (req[cand[IdW-1:0]]) begin
        win       = cand[IdW-1:0];
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IdW'(i)) begin
        owner_data = data_in[32*i +: 32];
      end
    end
  end

  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign owner_req = |(req & owner_oh);
  assign others    = req & ~owner_oh;
  assign hold_inc  = (hold_q == HoldW'(HOLD_CYCLES)) ? hold_q : hold_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    num_d   = num_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (win_valid) begin
          state_d = StOwn;
          owner_d = win;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StOwn: begin
        num_d  = owner_data;
        hold_d = hold_inc;
        // hold_inc counts this cycle, so an owner keeps the display exactly HOLD_CYCLES cycles.
        if (!owner_req || ((hold_inc == HoldW'(HOLD_CYCLES)) && (|others))) begin
          state_d = StGap;
          ptr_d   = (owner_q == IdW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      num_q   <= num_d;
    end
  end

  assign busy           = (state_q == StOwn);
  assign power_on       = busy;
  assign grant          = busy ? owner_oh : '0;
  assign owner_id       = owner_q;
  assign numero_entrada = num_q;
  assign clk_display    = clk_disp_q;

endmodule
